// File: rtl/seq_sum_deserializer.sv
// seq_sum_deserializer
// Receive side of the bit-serial adder. Collects an LSB-first sum bitstream
// and the final carry into a parallel WIDTH-bit result. The result is handed
// downstream over a valid/ready handshake. Stray bits outside a frame and
// restarts in the middle of a frame are flagged with a one-cycle err pulse.

module seq_sum_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_bit,
  input  logic             c_bit,
  input  logic             s_start,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] sum_shift;
  logic             cout_nxt;
  logic             err_nxt;
  logic             accept;
  logic             last_bit;

  // Input is blocked only while a finished result is waiting downstream.
  assign s_ready   = (state != HOLD);
  assign accept    = s_valid && s_ready;
  assign sum_shift = {s_bit, sum[WIDTH-1:1]};
  assign last_bit  = ((cnt + CW'(1)) == CW'(WIDTH));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && s_start) begin
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (accept && !s_start && last_bit) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values: shift register, bit counter, carry capture, error.
  always_comb begin
    sum_nxt  = sum;
    cnt_nxt  = cnt;
    cout_nxt = cout;
    err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (s_start) begin
            sum_nxt = sum_shift;
            cnt_nxt = CW'(1);
          end else begin
            // Bit outside any frame: dropped, sum and cnt untouched.
            err_nxt = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          sum_nxt = sum_shift;
          if (s_start) begin
            // Restart: the partial frame is abandoned, this bit is bit 0.
            err_nxt = 1'b1;
            cnt_nxt = CW'(1);
          end else if (last_bit) begin
            cout_nxt = c_bit;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: begin
        // HOLD: result frozen; any presented bits are simply not accepted.
      end
    endcase
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      cnt       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sum       <= sum_nxt;
      cnt       <= cnt_nxt;
      cout      <= cout_nxt;
      err       <= err_nxt;
      out_valid <= (state_nxt == HOLD);
    end
  end

endmodule

// File: tb/tb_seq_sum_deserializer.sv
// Self-checking bench for seq_sum_deserializer: directed scenarios followed by
// random traffic, all compared against a frame-level queue model.

module tb_seq_sum_deserializer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         s_bit;
  logic         c_bit;
  logic         s_start;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
  logic         out_ready;
  logic         err;

  seq_sum_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_bit     (s_bit),
    .c_bit     (c_bit),
    .s_start   (s_start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: bits of the open frame, pending-result flag, last result.
  bit           m_bits[$];
  bit           m_hold;
  bit           m_err;
  bit           m_sum_known;
  logic [W-1:0] m_sum;
  bit           m_cout;
  int           done_cycs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_hold      = 1'b0;
    m_err       = 1'b0;
    m_sum       = '0;
    m_sum_known = 1'b1;
    m_cout      = 1'b0;
  endtask

  task automatic model_update(input bit v, input bit b, input bit c, input bit st, input bit o);
    m_err = 1'b0;
    if (m_hold) begin
      if (o) m_hold = 1'b0;
    end else if (v) begin
      if (st) begin
        if (m_bits.size() != 0) m_err = 1'b1;
        m_bits.delete();
        m_bits.push_back(b);
        m_sum_known = 1'b0;
      end else if (m_bits.size() == 0) begin
        m_err = 1'b1;
      end else begin
        m_bits.push_back(b);
      end
      if (m_bits.size() == W) begin
        m_sum = '0;
        foreach (m_bits[i]) m_sum[i] = m_bits[i];
        m_cout      = c;
        m_hold      = 1'b1;
        m_sum_known = 1'b1;
        m_bits.delete();
        done_cycs.push_back(cyc);
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(m_hold));
    chk("s_ready",   32'(s_ready),   32'(!m_hold));
    chk("err",       32'(err),       32'(m_err));
    chk("cout",      32'(cout),      32'(m_cout));
    if (m_sum_known) chk("sum", 32'(sum), 32'(m_sum));
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge.
  task automatic step(input bit v, input bit b, input bit c, input bit st, input bit o);
    s_valid   = v;
    s_bit     = b;
    c_bit     = c;
    s_start   = st;
    out_ready = o;
    @(posedge clk);
    model_update(v, b, c, st, o);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  // Send a full frame; junk bits are offered while a result is pending.
  task automatic send_frame(input logic [W-1:0] val, input bit c, input bit gapped, input bit o);
    for (int i = 0; i < int'(W); i++) begin
      int guard = 0;
      while (m_hold) begin
        step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), o);
        guard++;
        if (guard > 50) begin
          total++;
          bad++;
          $error("FAIL hold_timeout: observed=held expected=released (cycle %0d)", cyc);
          break;
        end
      end
      if (gapped && i > 0) step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), o);
      step(1'b1, val[i], (i == int'(W) - 1) ? c : 1'($urandom), (i == 0), o);
    end
  endtask

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_bit = 1'b0; c_bit = 1'b0; s_start = 1'b0; out_ready = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_sum", 32'(sum), 32'h0);
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 1: basic frame
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("t1_sum", 32'(sum), 32'h5A);
    chk("t1_cout", 32'(cout), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 2: gapped input, backpressure with bits driven during HOLD
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    chk("t2_sum", 32'(sum), 32'hC3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_idle_ready", 32'(s_ready), 32'h1);

    // 3: mid-frame restart on the 4th bit
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    chk("t3_sum", 32'(sum), 32'h81);
    chk("t3_cout", 32'(cout), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 4: stray bit in IDLE
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_sum_kept", 32'(sum), 32'h81);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("t4_sum", 32'(sum), 32'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 5: asynchronous reset after 5 bits of a frame
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, (i == 0), 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t5_sum", 32'(sum), 32'h0);
    check_all();
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    chk("t5_sum_after", 32'(sum), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 6: back-to-back frames with out_ready tied high
    done_cycs.delete();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    chk("t6_sum0", 32'(sum), 32'h01);
    send_frame(8'h80, 1'b1, 1'b0, 1'b1);
    chk("t6_sum1", 32'(sum), 32'h80);
    if (done_cycs.size() == 2) chk("t6_spacing", 32'(done_cycs[1] - done_cycs[0]), 32'(W + 1));
    else chk("t6_results", 32'(done_cycs.size()), 32'h2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_sum_deserializer.md
# seq_sum_deserializer

Receive side of the bit-serial adder datapath. Accepts the LSB-first sum bitstream and the running carry produced each cycle by the serial full-adder/carry-flop stage, and reassembles them into a parallel WIDTH-bit sum plus carry-out. Presents the result to downstream logic through a valid/ready handshake. Detects malformed streams: stray bits outside a frame, and restarts mid-frame.

## Interface
- WIDTH, 8: operand/sum width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- s_bit  in  1  serial sum bit for the current bit position.
- c_bit  in  1  carry-flop value after this bit position; only sampled on the last bit of a frame.
- s_start  in  1  qualifies s_bit as bit 0 (LSB) of a new frame.
- s_valid  in  1  s_bit/c_bit/s_start valid this cycle.
- s_ready  out  1  block can accept a bit; equals 1 whenever state != HOLD.
- sum  out  WIDTH  assembled sum; stable while out_valid=1.
- cout  out  1  final carry of the frame.
- out_valid  out  1  sum/cout valid.
- out_ready  in  1  downstream accepts result.
- err  out  1  one-cycle pulse on protocol error.

## Operation
- A bit is accepted in any cycle where s_valid=1 and s_ready=1.
- Shift rule for each accepted bit in a frame: sum <= {s_bit, sum[WIDTH-1:1]}. After WIDTH accepted bits, bit 0 of the frame sits in sum[0].
- Bit counter cnt is $clog2(WIDTH)+1 bits wide and counts accepted bits in the current frame.
- **State IDLE**
  - s_ready=1.
  - Accepted bit with s_start=1: load sum <= {s_bit, sum[WIDTH-1:1]}, set cnt=1, go to COLLECT.
  - Accepted bit with s_start=0: bit is dropped, err pulses, state stays IDLE, sum and cnt unchanged.
- **State COLLECT**
  - s_ready=1.
  - Accepted bit with s_start=0: shift, cnt++.
  - When the accepted bit brings cnt to WIDTH: capture cout <= c_bit, go to HOLD.
  - Accepted bit with s_start=1: discard the partial frame, err pulses, restart the frame with this bit (shift it in, cnt=1), stay in COLLECT.
  - Cycles with s_valid=0: hold everything unchanged. There is no timeout.
- **State HOLD**
  - out_valid=1, s_ready=0. Any s_valid is ignored and raises no err.
  - out_ready=1: go to IDLE, out_valid drops next cycle. sum and cout keep their values until overwritten by the next frame.
- out_valid is registered and equals (state == HOLD).
- **Reset, any time including mid-frame:** state=IDLE, sum=0, cout=0, cnt=0, out_valid=0, err=0. s_ready=1 while in reset. A partial frame is lost with no err.

## Timing
- Latency: out_valid rises on the clock edge that accepts the WIDTH-th bit, so it is visible the cycle after that bit is presented.
- Minimum frame time is WIDTH cycles. The minimum period between results is WIDTH+1 cycles, because the HOLD→IDLE cycle blocks input.
- No combinational path from s_valid or out_ready to outputs, except s_ready, which decodes state only.
- err is registered and is high for exactly one cycle after the offending accept.
- HOLD with out_ready tied 1 lasts exactly one cycle.

## Test plan
1. **Basic frame:** WIDTH=8, stream 0x5A LSB-first on 8 consecutive cycles, s_start on first bit, c_bit=1 on last bit → out_valid high cycle 9, sum=0x5A, cout=1, err never asserted.
2. **Gapped input and backpressure:** frame 0xC3 with s_valid low on alternate cycles, out_ready held 0 for 5 cycles after out_valid, with s_valid=1 bits driven during HOLD → s_ready=0 throughout HOLD, sum stays 0xC3, those bits have no effect, IDLE entered the cycle after out_ready=1.
3. **Mid-frame restart:** s_start reasserted on the 4th bit of a frame, then a full 8-bit stream 0x81 with c_bit=0 → single err pulse one cycle after that bit, result sum=0x81, cout=0.
4. **Stray bit in IDLE:** s_valid=1, s_start=0 while IDLE → err pulses once, sum unchanged. A following frame 0xFF with c_bit=1 completes with sum=0xFF, cout=1.
5. **Reset mid-frame:** assert rst asynchronously after 5 bits of a frame → outputs immediately sum=0, cout=0, out_valid=0, s_ready=1. A subsequent full frame 0x3C completes correctly.
6. **Back-to-back frames:** out_ready tied 1, frames 0x01 then 0x80 with no idle cycles offered → results delivered 9 cycles apart with correct values, no err.
